// File: rtl/cpu_pkg.sv
// Shared decode encodings for the integer pipeline: opcodes, instruction
// classes (aluop), sub-operations (alusel) and their NOP values.
package cpu_pkg;

  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned ALUSEL_W = 5;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [ALUOP_W-1:0] {
    AOP_NOP    = 4'd0,
    AOP_LUI    = 4'd1,
    AOP_AUIPC  = 4'd2,
    AOP_JAL    = 4'd3,
    AOP_JALR   = 4'd4,
    AOP_BRANCH = 4'd5,
    AOP_LOAD   = 4'd6,
    AOP_STORE  = 4'd7,
    AOP_OPIMM  = 4'd8,
    AOP_OP     = 4'd9
  } aluop_e;

  typedef enum logic [ALUSEL_W-1:0] {
    SEL_NOP  = 5'd0,
    SEL_ADD  = 5'd1,
    SEL_SUB  = 5'd2,
    SEL_SLL  = 5'd3,
    SEL_SLT  = 5'd4,
    SEL_SLTU = 5'd5,
    SEL_XOR  = 5'd6,
    SEL_SRL  = 5'd7,
    SEL_SRA  = 5'd8,
    SEL_OR   = 5'd9,
    SEL_AND  = 5'd10,
    SEL_BEQ  = 5'd11,
    SEL_BNE  = 5'd12,
    SEL_BLT  = 5'd13,
    SEL_BGE  = 5'd14,
    SEL_BLTU = 5'd15,
    SEL_BGEU = 5'd16,
    SEL_LB   = 5'd17,
    SEL_LH   = 5'd18,
    SEL_LW   = 5'd19,
    SEL_LBU  = 5'd20,
    SEL_LHU  = 5'd21,
    SEL_SB   = 5'd22,
    SEL_SH   = 5'd23,
    SEL_SW   = 5'd24
  } alusel_e;

  localparam aluop_e  ALUOP_NOP  = AOP_NOP;
  localparam alusel_e ALUSEL_NOP = SEL_NOP;

  // Arithmetic sub-operation for OP / OP-IMM; alt is inst[30].
  // SUB exists only for register-register ops, SRA/SRAI for both.
  function automatic alusel_e alu_sel(input logic [2:0] f3, input logic alt,
                                      input logic is_op);
    alusel_e s;
    case (f3)
      3'b000:  s = (is_op && alt) ? SEL_SUB : SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = alt ? SEL_SRA : SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: register fields, immediates, class,
// sub-operation, source usage, destination and illegal detection.
import cpu_pkg::*;

module id_decode #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
) (
  input  logic [31:0]     inst,
  output logic [RAW-1:0]  rs1,
  output logic [RAW-1:0]  rs2,
  output logic            use1,
  output logic            use2,
  output aluop_e          aluop,
  output alusel_e         alusel,
  output logic [XLEN-1:0] imm,
  output logic            wreg,
  output logic [RAW-1:0]  wd,
  output logic            illegal
);

  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        wr;

  assign f3  = inst[14:12];
  assign rs1 = RAW'(inst[19:15]);
  assign rs2 = RAW'(inst[24:20]);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    aluop   = AOP_NOP;
    alusel  = SEL_NOP;
    imm32   = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    wr      = 1'b0;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LUI:   begin aluop = AOP_LUI;   alusel = SEL_ADD; imm32 = imm_u; wr = 1'b1; end
      OPC_AUIPC: begin aluop = AOP_AUIPC; alusel = SEL_ADD; imm32 = imm_u; wr = 1'b1; end
      OPC_JAL:   begin aluop = AOP_JAL;   alusel = SEL_ADD; imm32 = imm_j; wr = 1'b1; end
      OPC_JALR: begin
        aluop = AOP_JALR; alusel = SEL_ADD; imm32 = imm_i; use1 = 1'b1; wr = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        aluop = AOP_BRANCH; imm32 = imm_b; use1 = 1'b1; use2 = 1'b1;
        case (f3)
          3'b000:  alusel = SEL_BEQ;
          3'b001:  alusel = SEL_BNE;
          3'b100:  alusel = SEL_BLT;
          3'b101:  alusel = SEL_BGE;
          3'b110:  alusel = SEL_BLTU;
          3'b111:  alusel = SEL_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        aluop = AOP_LOAD; imm32 = imm_i; use1 = 1'b1; wr = 1'b1;
        case (f3)
          3'b000:  alusel = SEL_LB;
          3'b001:  alusel = SEL_LH;
          3'b010:  alusel = SEL_LW;
          3'b100:  alusel = SEL_LBU;
          3'b101:  alusel = SEL_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        aluop = AOP_STORE; imm32 = imm_s; use1 = 1'b1; use2 = 1'b1;
        case (f3)
          3'b000:  alusel = SEL_SB;
          3'b001:  alusel = SEL_SH;
          3'b010:  alusel = SEL_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        aluop = AOP_OPIMM; alusel = alu_sel(f3, inst[30], 1'b0);
        imm32 = imm_i; use1 = 1'b1; wr = 1'b1;
      end
      OPC_OP: begin
        aluop = AOP_OP; alusel = alu_sel(f3, inst[30], 1'b1);
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal word must not read, write or carry an immediate.
    if (illegal) begin
      aluop  = ALUOP_NOP;
      alusel = ALUSEL_NOP;
      imm32  = '0;
      use1   = 1'b0;
      use2   = 1'b0;
      wr     = 1'b0;
    end
  end

  assign imm  = XLEN'($signed(imm32));
  assign wreg = wr && (inst[11:7] != 5'd0);
  assign wd   = wreg ? RAW'(inst[11:7]) : '0;

endmodule

// File: rtl/id_pipe.sv
// Decode stage: operand forwarding with load-use stall, and the registered
// valid/ready output bundle handed to execute.
import cpu_pkg::*;

module id_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2,
  parameter int unsigned RAW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  input  logic [NFWD-1:0]      fwd_wreg,
  input  logic [NFWD*RAW-1:0]  fwd_wd,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_pend,
  output logic [RAW-1:0]       rf_raddr1,
  output logic [RAW-1:0]       rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output aluop_e               out_aluop,
  output alusel_e              out_alusel,
  output logic                 out_wreg,
  output logic [RAW-1:0]       out_wd,
  output logic                 out_illegal
);

  logic [RAW-1:0]  rs1, rs2, d_wd;
  logic            use1, use2, d_wreg, d_illegal;
  aluop_e          d_aluop;
  alusel_e         d_alusel;
  logic [XLEN-1:0] d_imm, op1, op2;
  logic            pend1, pend2, stall, load;

  id_decode #(.XLEN(XLEN), .RAW(RAW)) u_decode (
    .inst    (in_inst),
    .rs1     (rs1),
    .rs2     (rs2),
    .use1    (use1),
    .use2    (use2),
    .aluop   (d_aluop),
    .alusel  (d_alusel),
    .imm     (d_imm),
    .wreg    (d_wreg),
    .wd      (d_wd),
    .illegal (d_illegal)
  );

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    op1   = '0;
    op2   = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (use1 && rs1 != '0) op1 = rf_rdata1;
    if (use2 && rs2 != '0) op2 = rf_rdata2;
    // Walk from the highest index down so the lowest matching source wins.
    for (int unsigned k = 0; k < NFWD; k++) begin
      if (use1 && rs1 != '0 && fwd_wreg[NFWD-1-k] &&
          fwd_wd[(NFWD-1-k)*RAW +: RAW] == rs1) begin
        op1   = fwd_wdata[(NFWD-1-k)*XLEN +: XLEN];
        pend1 = fwd_pend[NFWD-1-k];
      end
      if (use2 && rs2 != '0 && fwd_wreg[NFWD-1-k] &&
          fwd_wd[(NFWD-1-k)*RAW +: RAW] == rs2) begin
        op2   = fwd_wdata[(NFWD-1-k)*XLEN +: XLEN];
        pend2 = fwd_pend[NFWD-1-k];
      end
    end
  end

  assign stall    = in_valid && (pend1 || pend2);
  assign in_ready = !rst && (!out_valid || out_ready) && !stall && !flush;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_aluop   <= ALUOP_NOP;
      out_alusel  <= ALUSEL_NOP;
      out_wreg    <= 1'b0;
      out_wd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_imm     <= d_imm;
      out_op1     <= op1;
      out_op2     <= op2;
      out_aluop   <= d_aluop;
      out_alusel  <= d_alusel;
      out_wreg    <= d_wreg;
      out_wd      <= d_wd;
      out_illegal <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: reset, table of decode vectors, handshake corner
// sequences, then randomized traffic against a behavioural model.
import cpu_pkg::*;

module tb_id_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NFWD = 2;
  localparam int unsigned RAW  = 5;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]          in_pc, in_inst, rf_rdata1, rf_rdata2;
  logic [NFWD-1:0]      fwd_wreg, fwd_pend;
  logic [NFWD*RAW-1:0]  fwd_wd;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [RAW-1:0]       rf_raddr1, rf_raddr2, out_wd;
  logic [31:0]          out_pc, out_imm, out_op1, out_op2;
  aluop_e               out_aluop;
  alusel_e              out_alusel;
  logic                 out_wreg, out_illegal;

  logic        f_wreg [NFWD];
  logic [4:0]  f_wd   [NFWD];
  logic [31:0] f_data [NFWD];
  logic        f_pend [NFWD];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    fwd_wreg  = '0;
    fwd_pend  = '0;
    fwd_wd    = '0;
    fwd_wdata = '0;
    for (int i = 0; i < NFWD; i++) begin
      fwd_wreg[i]               = f_wreg[i];
      fwd_pend[i]               = f_pend[i];
      fwd_wd[i*RAW +: RAW]      = f_wd[i];
      fwd_wdata[i*XLEN +: XLEN] = f_data[i];
    end
  end

  id_pipe #(.XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd),
    .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_op1(out_op1), .out_op2(out_op2), .out_aluop(out_aluop),
    .out_alusel(out_alusel), .out_wreg(out_wreg), .out_wd(out_wd),
    .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] pc, imm, op1, op2;
    aluop_e      aluop;
    alusel_e     alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        ill;
  } bundle_t;

  typedef struct {
    logic [31:0] inst, pc, r1, r2;
    aluop_e      aluop;
    alusel_e     alusel;
    logic [31:0] imm, op1, op2;
    logic        wreg;
    logic [4:0]  wd;
    logic        ill;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input bundle_t e);
    chk({tag, "_pc"},     out_pc,      e.pc);
    chk({tag, "_imm"},    out_imm,     e.imm);
    chk({tag, "_op1"},    out_op1,     e.op1);
    chk({tag, "_op2"},    out_op2,     e.op2);
    chk({tag, "_aluop"},  out_aluop,   e.aluop);
    chk({tag, "_alusel"}, out_alusel,  e.alusel);
    chk({tag, "_wreg"},   out_wreg,    e.wreg);
    chk({tag, "_wd"},     out_wd,      e.wd);
    chk({tag, "_ill"},    out_illegal, e.ill);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    for (int i = 0; i < NFWD; i++) begin
      f_wreg[i] = 1'b0; f_wd[i] = 5'd0; f_data[i] = 32'd0; f_pend[i] = 1'b0;
    end
  endtask

  // Operand value for source register rs: x0 reads zero, the first forwarding
  // source naming rs wins, otherwise the register file value.
  function automatic logic [31:0] opval(input logic [4:0] rs, input logic [31:0] rf,
                                        output logic pend);
    pend = 1'b0;
    if (rs == 5'd0) return 32'd0;
    for (int n = 0; n < NFWD; n++)
      if (f_wreg[n] && f_wd[n] == rs) begin
        pend = f_pend[n];
        return f_data[n];
      end
    return rf;
  endfunction

  // Reference decode straight from the ISA field definitions.
  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         output logic stl);
    bundle_t     b;
    logic        u1, u2, wr, ok, p1, p2;
    logic [2:0]  f3;
    logic [31:0] sgn, ii, is, ib, iu, ij;
    alusel_e     ar [8];
    alusel_e     br [8];
    alusel_e     ld [8];
    ar = '{SEL_ADD, SEL_SLL, SEL_SLT, SEL_SLTU, SEL_XOR, SEL_SRL, SEL_OR, SEL_AND};
    br = '{SEL_BEQ, SEL_BNE, SEL_NOP, SEL_NOP, SEL_BLT, SEL_BGE, SEL_BLTU, SEL_BGEU};
    ld = '{SEL_LB, SEL_LH, SEL_LW, SEL_NOP, SEL_LBU, SEL_LHU, SEL_NOP, SEL_NOP};
    f3  = inst[14:12];
    sgn = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    ii  = (sgn & 32'hFFFF_F800) | inst[30:20];
    is  = (sgn & 32'hFFFF_F800) | (inst[30:25] << 5) | inst[11:7];
    ib  = (sgn & 32'hFFFF_F000) | (inst[7] << 11) | (inst[30:25] << 5) | (inst[11:8] << 1);
    iu  = inst & 32'hFFFF_F000;
    ij  = (sgn & 32'hFFF0_0000) | (inst[19:12] << 12) | (inst[20] << 11) | (inst[30:21] << 1);
    b.pc = pc; b.imm = 0; b.op1 = 0; b.op2 = 0; b.aluop = AOP_NOP; b.alusel = SEL_NOP;
    b.wreg = 1'b0; b.wd = 5'd0; b.ill = 1'b0;
    u1 = 1'b0; u2 = 1'b0; wr = 1'b0; ok = 1'b1; p1 = 1'b0; p2 = 1'b0;
    case (inst[6:0])
      7'h37: begin b.aluop = AOP_LUI;   b.alusel = SEL_ADD; b.imm = iu; wr = 1'b1; end
      7'h17: begin b.aluop = AOP_AUIPC; b.alusel = SEL_ADD; b.imm = iu; wr = 1'b1; end
      7'h6F: begin b.aluop = AOP_JAL;   b.alusel = SEL_ADD; b.imm = ij; wr = 1'b1; end
      7'h67: begin b.aluop = AOP_JALR; b.alusel = SEL_ADD; b.imm = ii; u1 = 1'b1; wr = 1'b1;
                   ok = (f3 == 3'd0); end
      7'h63: begin b.aluop = AOP_BRANCH; b.alusel = br[f3]; b.imm = ib; u1 = 1'b1; u2 = 1'b1;
                   ok = (br[f3] != SEL_NOP); end
      7'h03: begin b.aluop = AOP_LOAD; b.alusel = ld[f3]; b.imm = ii; u1 = 1'b1; wr = 1'b1;
                   ok = (ld[f3] != SEL_NOP); end
      7'h23: begin b.aluop = AOP_STORE; b.imm = is; u1 = 1'b1; u2 = 1'b1; ok = (f3 < 3);
                   b.alusel = (f3 == 0) ? SEL_SB : (f3 == 1) ? SEL_SH : SEL_SW; end
      7'h13: begin b.aluop = AOP_OPIMM; b.alusel = ar[f3]; b.imm = ii; u1 = 1'b1; wr = 1'b1;
                   if (f3 == 5 && inst[30]) b.alusel = SEL_SRA; end
      7'h33: begin b.aluop = AOP_OP; b.alusel = ar[f3]; u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
                   if (f3 == 5 && inst[30]) b.alusel = SEL_SRA;
                   if (f3 == 0 && inst[30]) b.alusel = SEL_SUB; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b.aluop = AOP_NOP; b.alusel = SEL_NOP; b.imm = 0; b.ill = 1'b1;
      u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
    end
    b.wreg = wr && inst[11:7] != 5'd0;
    b.wd   = b.wreg ? inst[11:7] : 5'd0;
    if (u1) b.op1 = opval(inst[19:15], r1, p1);
    if (u2) b.op2 = opval(inst[24:20], r2, p2);
    stl = p1 || p2;
    return b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  opcs [9];
    int unsigned kind;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    r = $urandom;
    kind = $urandom_range(0, 10);
    if (kind < 9) r[6:0] = opcs[kind];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    if (r[6:0] == 7'h33) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  vec_t    tbl [11];
  bundle_t e, zero_b, m_b;
  logic    stl, m_valid, m_rst, exp_ready;

  initial begin
    zero_b = '{32'd0, 32'd0, 32'd0, 32'd0, AOP_NOP, SEL_NOP, 1'b0, 5'd0, 1'b0};
    tbl[0]  = '{32'h00500093, 32'h100, 32'h11,   32'h22,   AOP_OPIMM,  SEL_ADD, 32'd5,        32'h0,    32'h0,    1'b1, 5'd1, 1'b0};
    tbl[1]  = '{32'h4030D093, 32'h104, 32'h80,   32'h22,   AOP_OPIMM,  SEL_SRA, 32'h403,      32'h80,   32'h0,    1'b1, 5'd1, 1'b0};
    tbl[2]  = '{32'hFFFFFFFF, 32'h108, 32'h33,   32'h44,   AOP_NOP,    SEL_NOP, 32'h0,        32'h0,    32'h0,    1'b0, 5'd0, 1'b1};
    tbl[3]  = '{32'h123452B7, 32'h10C, 32'h1,    32'h2,    AOP_LUI,    SEL_ADD, 32'h12345000, 32'h0,    32'h0,    1'b1, 5'd5, 1'b0};
    tbl[4]  = '{32'hFE21AE23, 32'h110, 32'h1000, 32'hABCD, AOP_STORE,  SEL_SW,  32'hFFFFFFFC, 32'h1000, 32'hABCD, 1'b0, 5'd0, 1'b0};
    tbl[5]  = '{32'hFE208CE3, 32'h114, 32'h5,    32'h6,    AOP_BRANCH, SEL_BEQ, 32'hFFFFFFF8, 32'h5,    32'h6,    1'b0, 5'd0, 1'b0};
    tbl[6]  = '{32'h010000EF, 32'h118, 32'h7,    32'h8,    AOP_JAL,    SEL_ADD, 32'h10,       32'h0,    32'h0,    1'b1, 5'd1, 1'b0};
    tbl[7]  = '{32'h402081B3, 32'h11C, 32'h9,    32'h4,    AOP_OP,     SEL_SUB, 32'h0,        32'h9,    32'h4,    1'b1, 5'd3, 1'b0};
    tbl[8]  = '{32'h00108013, 32'h120, 32'h77,   32'h5,    AOP_OPIMM,  SEL_ADD, 32'h1,        32'h77,   32'h0,    1'b0, 5'd0, 1'b0};
    tbl[9]  = '{32'h0000B083, 32'h124, 32'h3,    32'h3,    AOP_NOP,    SEL_NOP, 32'h0,        32'h0,    32'h0,    1'b0, 5'd0, 1'b1};
    tbl[10] = '{32'hFFF12203, 32'h128, 32'h200,  32'h3,    AOP_LOAD,   SEL_LW,  32'hFFFFFFFF, 32'h200,  32'h0,    1'b1, 5'd4, 1'b0};

    // Reset: in_ready held low even with an offer, bundle cleared.
    clear_fwd();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h40; in_inst = 32'h00500093; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    step(); step();
    chk("rst_in_ready2", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    check_bundle("rst", zero_b);
    rst = 1'b0;

    // Decode table, back-to-back with out_ready high.
    for (int i = 0; i < 11; i++) begin
      in_inst = tbl[i].inst; in_pc = tbl[i].pc;
      rf_rdata1 = tbl[i].r1; rf_rdata2 = tbl[i].r2;
      #1;
      chk("tbl_in_ready", in_ready, 1'b1);
      chk("tbl_raddr1", rf_raddr1, tbl[i].inst[19:15]);
      step();
      e = '{tbl[i].pc, tbl[i].imm, tbl[i].op1, tbl[i].op2, tbl[i].aluop, tbl[i].alusel,
            tbl[i].wreg, tbl[i].wd, tbl[i].ill};
      chk("tbl_out_valid", out_valid, 1'b1);
      check_bundle($sformatf("tbl%0d", i), e);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", out_valid, 1'b0);

    // Priority forwarding: ADD x3,x1,x2 with both sources claiming x1.
    f_wreg[0] = 1'b1; f_wd[0] = 5'd1; f_data[0] = 32'hA;
    f_wreg[1] = 1'b1; f_wd[1] = 5'd1; f_data[1] = 32'hB;
    in_valid = 1'b1; in_inst = 32'h002081B3; rf_rdata1 = 32'h55; rf_rdata2 = 32'h7;
    step();
    chk("fwd_valid", out_valid, 1'b1);
    chk("fwd_op1", out_op1, 32'hA);
    chk("fwd_op2", out_op2, 32'h7);

    // Load-use: ADD x5,x4,x4 waits on a pending x4.
    clear_fwd();
    f_wreg[0] = 1'b1; f_wd[0] = 5'd4; f_pend[0] = 1'b1; f_data[0] = 32'hDEAD;
    in_inst = 32'h004202B3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("pend_in_ready", in_ready, 1'b0);
      step();
      chk("pend_out_valid", out_valid, 1'b0);
    end
    f_pend[0] = 1'b0; f_data[0] = 32'h1234;
    #1;
    chk("pend_release_ready", in_ready, 1'b1);
    step();
    chk("pend_rel_valid", out_valid, 1'b1);
    chk("pend_rel_op1", out_op1, 32'h1234);
    chk("pend_rel_op2", out_op2, 32'h1234);

    // Backpressure: bundle held for three cycles, then next one loads.
    clear_fwd();
    in_inst = 32'h00500093;
    step();
    out_ready = 1'b0; in_inst = 32'h00900113;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_imm", out_imm, 32'd5);
      chk("bp_wd", out_wd, 5'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    chk("bp_next_imm", out_imm, 32'd9);
    chk("bp_next_wd", out_wd, 5'd2);

    // Flush with a valid bundle and a stalled offer.
    out_ready = 1'b0;
    f_wreg[0] = 1'b1; f_wd[0] = 5'd4; f_pend[0] = 1'b1;
    in_inst = 32'h004202B3; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; clear_fwd();
    step();
    chk("flush_no_emit", out_valid, 1'b0);

    // Reset while back-pressured drops the held bundle.
    in_valid = 1'b1; in_inst = 32'h00500093; out_ready = 1'b1;
    step();
    out_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rst_bp_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    chk("rst_bp_valid", out_valid, 1'b0);
    check_bundle("rst_bp", zero_b);

    // Randomized traffic against the model.
    m_valid = 1'b0; m_rst = 1'b1; m_b = zero_b;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", out_valid, m_valid);
      if (m_valid || m_rst) check_bundle("rnd", m_b);
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = gen_inst();
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      for (int i = 0; i < NFWD; i++) begin
        f_wreg[i] = 1'($urandom_range(0, 1));
        f_wd[i]   = 5'($urandom_range(0, 7));
        f_data[i] = $urandom;
        f_pend[i] = ($urandom_range(0, 3) == 0);
      end
      #1;
      e = ref_decode(in_inst, in_pc, rf_rdata1, rf_rdata2, stl);
      exp_ready = !rst && (!m_valid || out_ready) && !(in_valid && stl) && !flush;
      chk("rnd_in_ready", in_ready, exp_ready);
      chk("rnd_raddr2", rf_raddr2, in_inst[24:20]);
      if (rst) begin
        m_valid = 1'b0; m_rst = 1'b1; m_b = zero_b;
      end else if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && exp_ready) begin
        m_valid = 1'b1; m_rst = 1'b0; m_b = e;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width.
REQ-002 SHALL have parameter NFWD, default 2, number of forwarding sources; index 0 has highest priority.
REQ-003 SHALL have parameter RAW, default 5, register address width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discard held and incoming instruction.
REQ-007 in_valid  in  1  fetch offers instruction.
REQ-008 in_ready  out  1  decode accepts instruction this cycle.
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 in_inst  in  32  instruction word.
REQ-011 fwd_wreg  in  NFWD  source n writes a register.
REQ-012 fwd_wd  in  NFWD*RAW  destination address of source n.
REQ-013 fwd_wdata  in  NFWD*XLEN  result of source n.
REQ-014 fwd_pend  in  NFWD  source n result not yet available (load in flight).
REQ-015 rf_raddr1, rf_raddr2  out  RAW each  regfile read addresses (rs1, rs2), combinational from in_inst.
REQ-016 rf_rdata1, rf_rdata2  in  XLEN each  regfile read data, same cycle.
REQ-017 out_valid  out  1  decoded bundle valid.
REQ-018 out_ready  in  1  execute consumes bundle.
REQ-019 out_pc, out_imm, out_op1, out_op2  out  XLEN each  PC, immediate, resolved operands.
REQ-020 out_aluop, out_alusel  out  package widths  instruction class, sub-operation.
REQ-021 out_wreg  out  1; out_wd  out  RAW; out_illegal  out  1  unknown opcode/funct3.

Function
REQ-022 Output bundle SHALL be registered; latency in_valid&in_ready to out_valid = 1 cycle.
REQ-023 Register SHALL load when in_valid & in_ready; in_ready = (!out_valid | out_ready) & !stall & !flush.
REQ-024 When out_valid & !out_ready, all outputs SHALL hold stable.
REQ-025 When out_ready & out_valid and no new load, out_valid SHALL clear next cycle.
REQ-026 Decode SHALL cover LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP with I/S/B/U/J immediates sign-extended to XLEN.
REQ-027 OP-IMM funct3=101 SHALL select SRAI when inst[30]=1, else SRLI; OP 000/101 SHALL use inst[30] for SUB/SRA.
REQ-028 Undefined opcode or funct3 SHALL produce aluop NOP, wreg=0, out_illegal=1, out_valid still asserted.
REQ-029 Operand resolution per used source: lowest-index n with fwd_wreg[n] & fwd_wd[n]==rs & rs!=0 supplies fwd_wdata[n]; else regfile data; unused source = 0.
REQ-030 Address x0 SHALL never be forwarded; op value for rs=0 SHALL be 0.
REQ-031 stall SHALL assert when in_valid and the matching source selected per REQ-029 has fwd_pend=1.
REQ-032 During stall, in_ready=0; if out_ready, out_valid clears (bubble) and payload is don't-care.
REQ-033 out_wd SHALL be forced 0 and out_wreg 0 when rd=0.
REQ-034 flush SHALL clear out_valid next cycle and accept nothing that cycle; flush overrides stall and out_ready.

Reset
REQ-035 rst SHALL set out_valid=0, out_wreg=0, out_illegal=0, out_aluop/out_alusel=NOP, out_wd=0, all XLEN outputs=0.
REQ-036 in_ready SHALL be 0 while rst=1; rst mid-stall or mid-backpressure SHALL drop the held bundle.

Structure
REQ-037 Opcode class, aluop and alusel encodings, NOP constants SHALL live in shared package cpu_pkg.
REQ-038 Combinational field/immediate/class decode SHALL be sub-module id_decode; forwarding, stall and pipeline register in id_pipe.

Verification
REQ-039 ADDI x1,x0,5 with out_ready=1 -> next cycle out_valid=1, op1=0, imm=5, wd=1, wreg=1.
REQ-040 ADD x3,x1,x2; fwd0 wd=1 data=0xA, fwd1 wd=1 data=0xB, fwd1 wd=2 absent, rf_rdata2=7 -> op1=0xA, op2=7.
REQ-041 LW x4 pending in fwd0 (pend=1, wd=4), ADD x5,x4,x4 -> in_ready=0, out_valid=0 for each pend cycle; accept on pend=0 with forwarded data.
REQ-042 out_ready=0 for 3 cycles after valid bundle -> outputs unchanged, in_ready=0; release -> next instruction loaded.
REQ-043 Flush while out_valid=1 and stall active -> out_valid=0 next cycle, no bundle emitted.
REQ-044 inst=0xFFFFFFFF -> out_illegal=1, wreg=0; SRAI x1,x1,3 (0x4030D093) -> alusel=SRAI.
